// File: rtl/dfg_inv_chain_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dfg_chain_pkg
// Description : Shared helpers for the invert/copy chain pipeline:
//               the per-stage data transform and the occupancy-count width.
//               Data is carried at a fixed maximum width so no WIDTH-dependent
//               types live here; callers cast to their own WIDTH.
// Revision    : 1.0  initial release
// ============================================================================
package dfg_chain_pkg;

  // Widest data word the transform helper can carry.
  localparam int XFORM_MAX_W = 256;

  // Bitwise invert when inv is set, plain copy otherwise.
  function automatic logic [XFORM_MAX_W-1:0] stage_xform(
    input logic [XFORM_MAX_W-1:0] data,
    input logic                   inv
  );
    return inv ? ~data : data;
  endfunction

  // Bits needed to hold a count in 0..depth.
  function automatic int count_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage : dfg_chain_pkg
`default_nettype wire

// File: rtl/dfg_inv_chain_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : dfg_inv_chain_pipe_if
// Description : Handshake bundle for dfg_inv_chain_pipe.
//   flush      synchronous pipeline flush        (master -> slave)
//   in_valid   upstream word present             (master -> slave)
//   in_data    upstream word, WIDTH bits         (master -> slave)
//   in_ready   stage 0 can accept                (slave  -> master)
//   out_valid  last stage holds a word           (slave  -> master)
//   out_data   last stage data, WIDTH bits       (slave  -> master)
//   out_ready  downstream accepts                (master -> slave)
//   count      number of valid stages            (slave  -> master)
// Revision    : 1.0  initial release
// ============================================================================
interface dfg_inv_chain_pipe_if
  import dfg_chain_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 3
);
  localparam int CNT_W = count_width(DEPTH);

  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CNT_W-1:0] count;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );

endinterface : dfg_inv_chain_pipe_if
`default_nettype wire

// File: rtl/dfg_inv_chain_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : dfg_chain_stage
// Description : One data/valid register pair of the chain. Loads the
//               (optionally inverted) source word when ready and the source
//               is valid; clears valid when its word leaves and nothing new
//               arrives. Flush clears valid only; data is left alone.
//   clk, rst    clock, asynchronous active-high reset
//   flush       synchronous valid clear
//   src_valid   source word valid (already qualified for stage 0)
//   src_data    source word
//   next_ready  ready of the successor (out_ready for the last stage)
//   data, valid stage registers
//   ready       !valid | next_ready
// Revision    : 1.0  initial release
// ============================================================================
module dfg_chain_stage
  import dfg_chain_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter bit               INV       = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  input  logic             next_ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             ready
);

  logic [WIDTH-1:0] xform_data;

  assign xform_data = WIDTH'(stage_xform(XFORM_MAX_W'(src_data), INV));
  assign ready      = !valid | next_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= RESET_VAL;
      valid <= 1'b0;
    end else begin
      if (flush) begin
        valid <= 1'b0;
      end else if (ready) begin
        // Empty source means our word left (or we were empty): go invalid.
        valid <= src_valid;
      end
      // Data is only written on a real load so a flush leaves it untouched.
      if (!flush && ready && src_valid) begin
        data <= xform_data;
      end
    end
  end

endmodule : dfg_chain_stage
`default_nettype wire

// File: rtl/dfg_inv_chain_pipe.sv
`default_nettype none
// ============================================================================
// Module      : dfg_inv_chain_pipe
// Description : DEPTH registered copy/invert stages with valid/ready
//               handshake, synchronous flush and occupancy count.
//               End-to-end out_data = in_data ^ {WIDTH{^INV_MASK}}.
//   clk   clock, rising edge
//   rst   asynchronous active-high reset
//   bus   dfg_inv_chain_pipe_if.slave (flush, in_*, out_*, count)
// Build option: DFG_CHAIN_BACKPRESSURE_EN
//   defined   : full ready chain, out_ready stalls the pipeline
//   undefined : out_ready ignored, every stage advances each cycle,
//               in_ready = !flush
// Revision    : 1.0  initial release
// ============================================================================
module dfg_inv_chain_pipe
  import dfg_chain_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 3,
  parameter logic [DEPTH-1:0] INV_MASK  = DEPTH'(1),
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  dfg_inv_chain_pipe_if.slave  bus
);

  localparam int CNT_W = count_width(DEPTH);

  logic [WIDTH-1:0] data      [DEPTH];
  logic [WIDTH-1:0] src_data  [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] src_valid;
  logic [DEPTH:0]   ready;
  logic [CNT_W-1:0] cnt;

`ifdef DFG_CHAIN_BACKPRESSURE_EN
  assign ready[DEPTH] = bus.out_ready;
  assign bus.in_ready = ready[0] & !bus.flush;
`else
  logic unused_out_ready;
  logic unused_ready0;
  assign unused_out_ready = bus.out_ready;
  assign unused_ready0    = ready[0];
  assign ready[DEPTH]     = 1'b1;
  assign bus.in_ready     = !bus.flush;
`endif

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign src_valid[k] = bus.in_valid & bus.in_ready;
      assign src_data[k]  = bus.in_data;
    end else begin : g_rest
      assign src_valid[k] = valid[k-1];
      assign src_data[k]  = data[k-1];
    end

    dfg_chain_stage #(
      .WIDTH     (WIDTH),
      .INV       (INV_MASK[k]),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .flush      (bus.flush),
      .src_valid  (src_valid[k]),
      .src_data   (src_data[k]),
      .next_ready (ready[k+1]),
      .data       (data[k]),
      .valid      (valid[k]),
      .ready      (ready[k])
    );
  end

  always_comb begin
    cnt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      cnt = cnt + CNT_W'(valid[k]);
    end
  end

  assign bus.count     = cnt;
  assign bus.out_valid = valid[DEPTH-1];
  assign bus.out_data  = data[DEPTH-1];

endmodule : dfg_inv_chain_pipe
`default_nettype wire
